dm_cache_ctrl: RTL and testbench

- Parametrised direct-mapped, word-granular cache controller with a request/ready CPU handshake and a backing-memory port.
- Read misses refill automatically from memory.
- Writes are write-through and write-allocate.
- Sits between the datapath load/store unit and main memory; replaces the fixed 64-entry combinational-lookup cache.

---
 rtl/dm_cache_pkg.sv | 29 ++
 rtl/dm_cache_array.sv | 46 ++++
 rtl/dm_cache_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_cache_pkg.sv
// Shared types and helpers for the direct-mapped cache controller.
// Optional statistics counters are enabled with CACHE_STATS_EN (see dm_cache_ctrl).
package dm_cache_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        REFILL = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } cache_state_t;

    localparam int STAT_W = 32;

    // Number of index bits for a power-of-two line count.
    function automatic int calc_idx_w(input int lines);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(lines)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Line storage for the direct-mapped cache: valid/tag/data flops,
// combinational read port, single synchronous write port.
module dm_cache_array #(
    parameter int LINES  = 64,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r  [LINES];
    logic [DATA_W-1:0] data_r [LINES];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

    // Valid bits: cleared all at once by reset, set on a line fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload are left unreset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through / write-allocate cache controller.
// Define CACHE_STATS_EN to add saturating read hit/miss counters.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rden,
    input  logic              cpu_wren,
    input  logic [DATA_W-1:0] cpu_wrdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rddata,
    output logic              hit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wrdata,
    input  logic [DATA_W-1:0] mem_rddata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int IDX_W = calc_idx_w(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } line_t;

    cache_state_t      state_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              lookup_hit_r;

    logic [IDX_W-1:0]  rd_idx_s;
    logic [TAG_W-1:0]  probe_tag_s;
    line_t             rd_line_s;
    logic              probe_hit_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] wr_data_s;

    dm_cache_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx_s),
        .rd_valid (rd_line_s.valid),
        .rd_tag   (rd_line_s.tag),
        .rd_data  (rd_line_s.data),
        .wr_en    (wr_en_s),
        .wr_idx   (req_addr_r[IDX_W-1:0]),
        .wr_tag   (req_addr_r[ADDR_W-1:IDX_W]),
        .wr_data  (wr_data_s)
    );

    // Probe with the incoming address while idle so a hit can complete
    // in the cycle right after acceptance with a registered cpu_done.
    always_comb begin
        if (state_r == IDLE) begin
            rd_idx_s    = cpu_addr[IDX_W-1:0];
            probe_tag_s = cpu_addr[ADDR_W-1:IDX_W];
        end else begin
            rd_idx_s    = req_addr_r[IDX_W-1:0];
            probe_tag_s = req_addr_r[ADDR_W-1:IDX_W];
        end
        probe_hit_s = rd_line_s.valid && (rd_line_s.tag == probe_tag_s);
    end

    // Line fill on the acknowledging edge; an ack coincident with rst is dropped.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = mem_wrdata;
        case (state_r)
            REFILL: begin
                wr_en_s   = mem_ack && !rst;
                wr_data_s = mem_rddata;
            end
            WRITE: begin
                wr_en_s   = mem_ack && !rst;
                wr_data_s = mem_wrdata;
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_data_s = mem_wrdata;
            end
        endcase
    end

    // Controller FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            req_addr_r   <= '0;
            lookup_hit_r <= 1'b0;
            cpu_ready    <= 1'b1;
            cpu_done     <= 1'b0;
            hit          <= 1'b0;
            cpu_rddata   <= '0;
            mem_rden     <= 1'b0;
            mem_wren     <= 1'b0;
            mem_addr     <= '0;
            mem_wrdata   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_done <= 1'b0;
                    hit      <= 1'b0;
                    if (cpu_wren) begin
                        req_addr_r <= cpu_addr;
                        mem_addr   <= cpu_addr;
                        mem_wrdata <= cpu_wrdata;
                        mem_wren   <= 1'b1;
                        cpu_ready  <= 1'b0;
                        state_r    <= WRITE;
                    end else if (cpu_rden) begin
                        req_addr_r   <= cpu_addr;
                        lookup_hit_r <= probe_hit_s;
                        cpu_ready    <= 1'b0;
                        state_r      <= LOOKUP;
                        if (probe_hit_s) begin
                            cpu_done   <= 1'b1;
                            hit        <= 1'b1;
                            cpu_rddata <= rd_line_s.data;
                        end
                    end
                end
                LOOKUP: begin
                    cpu_done <= 1'b0;
                    hit      <= 1'b0;
                    if (lookup_hit_r) begin
                        cpu_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        mem_rden <= 1'b1;
                        mem_addr <= req_addr_r;
                        state_r  <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mem_rden   <= 1'b0;
                        cpu_done   <= 1'b1;
                        hit        <= 1'b0;
                        cpu_rddata <= mem_rddata;
                        state_r    <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_wren   <= 1'b0;
                        cpu_done   <= 1'b1;
                        hit        <= 1'b0;
                        cpu_rddata <= '0;
                        state_r    <= RESP;
                    end
                end
                RESP: begin
                    cpu_done  <= 1'b0;
                    hit       <= 1'b0;
                    cpu_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    cpu_done  <= 1'b0;
                    hit       <= 1'b0;
                    mem_rden  <= 1'b0;
                    mem_wren  <= 1'b0;
                    cpu_ready <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Read hit/miss counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_r == LOOKUP) begin
            if (lookup_hit_r) begin
                if (hit_count != {STAT_W{1'b1}}) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != {STAT_W{1'b1}}) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl (LINES=64).
// Counter checks are included when CACHE_STATS_EN is defined.
module tb_dm_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_rden;
    logic        cpu_wren;
    logic [31:0] cpu_wrdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rddata;
    logic        hit;
    logic [31:0] mem_addr;
    logic        mem_rden;
    logic        mem_wren;
    logic [31:0] mem_wrdata;
    logic [31:0] mem_rddata;
    logic        mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int vectors = 0;
    int errors  = 0;

    dm_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .LINES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_rden   (cpu_rden),
        .cpu_wren   (cpu_wren),
        .cpu_wrdata (cpu_wrdata),
        .cpu_ready  (cpu_ready),
        .cpu_done   (cpu_done),
        .cpu_rddata (cpu_rddata),
        .hit        (hit),
        .mem_addr   (mem_addr),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_wrdata (mem_wrdata),
        .mem_rddata (mem_rddata),
        .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Read transaction; on a miss the bench memory returns exp_data after ack_wait cycles.
    task automatic cpu_read(input string tag, input logic [31:0] addr, input bit exp_hit,
                            input int ack_wait, input logic [31:0] exp_data);
        check_eq({tag, ".ready"}, 64'(cpu_ready), 64'd1);
        cpu_addr = addr;
        cpu_rden = 1'b1;
        @(negedge clk);
        cpu_rden = 1'b0;
        check_eq({tag, ".busy"}, 64'(cpu_ready), 64'd0);
        check_eq({tag, ".lk_done"}, 64'(cpu_done), 64'(exp_hit));
        check_eq({tag, ".lk_rden"}, 64'(mem_rden), 64'd0);
        if (exp_hit) begin
            check_eq({tag, ".hit"}, 64'(hit), 64'd1);
            check_eq({tag, ".data"}, 64'(cpu_rddata), 64'(exp_data));
            @(negedge clk);
        end else begin
            @(negedge clk);
            for (int c = 1; c <= ack_wait; c++) begin
                check_eq({tag, ".rden"}, 64'(mem_rden), 64'd1);
                check_eq({tag, ".wren"}, 64'(mem_wren), 64'd0);
                check_eq({tag, ".maddr"}, 64'(mem_addr), 64'(addr));
                check_eq({tag, ".wait_done"}, 64'(cpu_done), 64'd0);
                if (c == ack_wait) begin
                    mem_ack    = 1'b1;
                    mem_rddata = exp_data;
                end
                @(negedge clk);
            end
            mem_ack    = 1'b0;
            mem_rddata = 32'h0;
            check_eq({tag, ".done"}, 64'(cpu_done), 64'd1);
            check_eq({tag, ".hit"}, 64'(hit), 64'd0);
            check_eq({tag, ".data"}, 64'(cpu_rddata), 64'(exp_data));
            check_eq({tag, ".rden_off"}, 64'(mem_rden), 64'd0);
            @(negedge clk);
        end
        check_eq({tag, ".idle_done"}, 64'(cpu_done), 64'd0);
        check_eq({tag, ".idle_rden"}, 64'(mem_rden), 64'd0);
    endtask

    task automatic cpu_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input bit also_rd, input int ack_wait);
        check_eq({tag, ".ready"}, 64'(cpu_ready), 64'd1);
        cpu_addr   = addr;
        cpu_wrdata = data;
        cpu_wren   = 1'b1;
        cpu_rden   = also_rd;
        @(negedge clk);
        cpu_wren   = 1'b0;
        cpu_rden   = 1'b0;
        for (int c = 1; c <= ack_wait; c++) begin
            check_eq({tag, ".wren"}, 64'(mem_wren), 64'd1);
            check_eq({tag, ".rden"}, 64'(mem_rden), 64'd0);
            check_eq({tag, ".maddr"}, 64'(mem_addr), 64'(addr));
            check_eq({tag, ".mdata"}, 64'(mem_wrdata), 64'(data));
            if (c == ack_wait) begin
                mem_ack = 1'b1;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check_eq({tag, ".done"}, 64'(cpu_done), 64'd1);
        check_eq({tag, ".hit"}, 64'(hit), 64'd0);
        check_eq({tag, ".rdata0"}, 64'(cpu_rddata), 64'd0);
        check_eq({tag, ".wren_off"}, 64'(mem_wren), 64'd0);
        @(negedge clk);
        check_eq({tag, ".idle"}, 64'(cpu_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        cpu_addr   = 32'h0;
        cpu_rden   = 1'b0;
        cpu_wren   = 1'b0;
        cpu_wrdata = 32'h0;
        mem_rddata = 32'h0;
        mem_ack    = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.ready", 64'(cpu_ready), 64'd1);
        check_eq("rst.done", 64'(cpu_done), 64'd0);
        check_eq("rst.hit", 64'(hit), 64'd0);
        check_eq("rst.rddata", 64'(cpu_rddata), 64'd0);
        check_eq("rst.rden", 64'(mem_rden), 64'd0);
        check_eq("rst.wren", 64'(mem_wren), 64'd0);
        check_eq("rst.maddr", 64'(mem_addr), 64'd0);
        check_eq("rst.mwdata", 64'(mem_wrdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        cpu_read("cold", 32'h0000_0045, 1'b0, 3, 32'hDEAD_BEEF);
        cpu_read("rehit", 32'h0000_0045, 1'b1, 0, 32'hDEAD_BEEF);
        cpu_write("wr10", 32'h0000_0010, 32'h1234_5678, 1'b0, 1);
        cpu_read("rd10", 32'h0000_0010, 1'b1, 0, 32'h1234_5678);
        cpu_read("fill05", 32'h0000_0005, 1'b0, 2, 32'h0505_0505);
        cpu_read("conf45", 32'h0000_0045, 1'b0, 1, 32'h4545_4545);
        cpu_read("conf05", 32'h0000_0005, 1'b0, 1, 32'h0505_0505);
        cpu_write("rdwr20", 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 1);
        cpu_read("rd20", 32'h0000_0020, 1'b1, 0, 32'hA5A5_A5A5);
        cpu_write("wr60", 32'h0000_0060, 32'h0BAD_F00D, 1'b0, 2);
        cpu_read("rd20b", 32'h0000_0020, 1'b0, 1, 32'h2020_2020);
`ifdef CACHE_STATS_EN
        check_eq("stat.hits", 64'(hit_count), 64'd3);
        check_eq("stat.miss", 64'(miss_count), 64'd5);
`endif

        // Reset while a refill is outstanding, with an ack landing on the reset edge and after.
        cpu_addr = 32'h0000_007F;
        cpu_rden = 1'b1;
        @(negedge clk);
        cpu_rden = 1'b0;
        @(negedge clk);
        check_eq("mid.rden", 64'(mem_rden), 64'd1);
        rst        = 1'b1;
        mem_ack    = 1'b1;
        mem_rddata = 32'h7777_7777;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid.rden_drop", 64'(mem_rden), 64'd0);
        check_eq("mid.ready", 64'(cpu_ready), 64'd1);
        check_eq("mid.done", 64'(cpu_done), 64'd0);
        @(negedge clk);
        mem_ack    = 1'b0;
        mem_rddata = 32'h0;
        check_eq("late.done", 64'(cpu_done), 64'd0);
        check_eq("late.ready", 64'(cpu_ready), 64'd1);
        check_eq("late.rden", 64'(mem_rden), 64'd0);
`ifdef CACHE_STATS_EN
        check_eq("stat.rst_hits", 64'(hit_count), 64'd0);
        check_eq("stat.rst_miss", 64'(miss_count), 64'd0);
`endif
        cpu_read("post10", 32'h0000_0010, 1'b0, 1, 32'h1111_1111);
        cpu_read("post7f", 32'h0000_007F, 1'b0, 1, 32'h7F7F_7F7F);
        cpu_read("post10h", 32'h0000_0010, 1'b1, 0, 32'h1111_1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
